pcie_tx_arbiter: RTL and testbench
==================================

# pcie_tx_arbiter

Round-robin arbiter that shares the PCIe core transmit AXI4-Stream interface (64-bit) between several TLP sources. Each source uses a `req`/`ack` handshake. A granted source owns the TX stream until it finishes a packet, or until it drops `req` between packets. The block sits between the decapsulation-side TX sources (Ethernet-to-PCIe FIFO readers, local completers) and the PCIe endpoint `s_axis_tx_*` port.

## Interface
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `C_DATA_WIDTH`, default 64: TX data width. Only 64 is supported.
- `KEEP_WIDTH`, default `C_DATA_WIDTH/8`: tkeep width.
- `TUSER_WIDTH`, default 4: TX tuser width.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit. Used only with `PCIE_TX_ARB_TIMEOUT_EN`.

Ports:
- `pcie_clk` in 1: sole clock.
- `pcie_rst_n` in 1: asynchronous, active-low reset.
- `req` in `NUM_REQ`: per-source request for the TX stream.
- `ack` out `NUM_REQ`: per-source grant, one-hot or zero.
- `in_tvalid` in `NUM_REQ`: per-source tvalid.
- `in_tlast` in `NUM_REQ`: per-source tlast.
- `in_tkeep` in `NUM_REQ*KEEP_WIDTH`: per-source tkeep. Source i occupies slice i.
- `in_tdata` in `NUM_REQ*C_DATA_WIDTH`: per-source tdata. Source i occupies slice i.
- `in_tuser` in `NUM_REQ*TUSER_WIDTH`: per-source tuser. Source i occupies slice i.
- `in_tready` out `NUM_REQ`: tready returned only to the granted source.
- `pcie_tready` in 1: tready from the PCIe core.
- `pcie_tvalid`, `pcie_tlast` out 1: stream to the core.
- `pcie_tkeep` out `KEEP_WIDTH`: stream to the core.
- `pcie_tdata` out `C_DATA_WIDTH`: stream to the core.
- `pcie_tuser` out `TUSER_WIDTH`: stream to the core.
- `grant_id` out `$clog2(NUM_REQ)`: index of the current or last grant.
- `busy` out 1: high in state GRANT.
- `err_proto` out 1: sticky error, `req` dropped mid-packet.
- `err_timeout` out 1: sticky error, watchdog fired.

## Operation
- State machine: IDLE and GRANT. Registers: `gnt` (index), `last` (round-robin pointer), `in_pkt` flag.
- **IDLE**
  - If any `req` is high, select the first requester with `req` high, scanning `last+1`, `last+2`, ... modulo `NUM_REQ`.
  - Register the winner into `gnt` and `last`, clear `in_pkt`, go to GRANT.
  - If no `req` is high, stay in IDLE.
- **GRANT**
  - `ack[gnt]` = 1.
  - Combinational mux: `pcie_t*` = `in_t*[gnt]`, and `in_tready[gnt]` = `pcie_tready`. All other `in_tready` are 0.
  - A beat is accepted when `pcie_tvalid & pcie_tready`.
  - Accepted beat with `tlast`=0: set `in_pkt`.
  - Accepted beat with `tlast`=1: clear `in_pkt`, go to IDLE.
  - `req[gnt]`=0 while `in_pkt`=0: go to IDLE with no beat.
  - `req[gnt]`=0 while `in_pkt`=1: set `err_proto` and keep the grant until the `tlast` beat.
- Outside GRANT: all `pcie_t*`, `in_tready` and `ack` are 0.
- Newly asserted requests are never granted mid-packet. Arbitration happens only in IDLE.
- Reset values:
  - State IDLE, `last`=`NUM_REQ-1` (requester 0 wins first), `gnt`=0, `in_pkt`=0.
  - All outputs 0, including both error flags.
- Reset asserted mid-packet: the stream is abandoned immediately and outputs go to 0 asynchronously. No tlast is generated.

## Timing
- `req` rising in IDLE at cycle n gives `ack` high at cycle n+1. Data can pass at n+1.
- `tlast` accepted at cycle t:
  - `ack` is still high at t and low at t+1 (IDLE).
  - The next grant's `ack` rises at t+2. There is one bubble cycle between packets.
- `req` drop observed at cycle t with `in_pkt`=0 gives `ack` low at t+1.
- The data path is combinational from the inputs to `pcie_t*`, so it adds zero latency.
- Back-to-back requests from the same source with others requesting: each other requester receives one grant before the same source is granted again.

## Configuration
- `PCIE_TX_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on grant and on every accepted beat, and increments each GRANT cycle with no accepted beat.
  - When the counter reaches `TIMEOUT_CYCLES`, the block goes to IDLE, sets `err_timeout`, and advances `last` past `gnt`. This applies even when `in_pkt`=1, so the packet is truncated.
- Not defined: no counter is built, `err_timeout` is tied to 0, and a grant is held indefinitely.

## Test plan
- **Single requester:** after reset, `req[0]`=1 at cycle 5 → `ack[0]`=1 at cycle 6. A 3-beat TLP (tdata `0xA0`, `0xA1`, `0xA2`, tkeep `0xFF`) appears unchanged on `pcie_t*`. `ack` falls the cycle after `tlast`.
- **Round-robin fairness:** both requesters hold `req`=1 continuously and send 2-beat packets → grant order 0, 1, 0, 1. There is exactly one idle cycle between packets, and `grant_id` toggles.
- **Backpressure:** `pcie_tready` low for 4 cycles mid-packet → `in_tready[gnt]` is low for the same 4 cycles, data is held, `in_tready` of the other requester stays 0, and there are no duplicate or lost beats.
- **Empty grant release:** `req[1]`=1 for 1 cycle with `tvalid`=0 → `ack[1]` is high for 1 cycle and returns to IDLE. `req[1]` dropping after beat 1 of 3 → `err_proto`=1 and the grant is held until `tlast`.
- **Reset mid-packet:** `pcie_rst_n` low during beat 2 → all outputs 0 in the same cycle. After release, `req` on 0 and 1 together → requester 0 is granted.
- **Timeout (macro on, `TIMEOUT_CYCLES`=16):** the granted source stalls `tvalid` for 16 cycles → `err_timeout`=1, `ack` drops, and the pending requester 1 is granted 2 cycles later.

Source files
------------

// File: rtl/pcie_tx_arbiter.sv
// Round-robin arbiter sharing the 64-bit PCIe TX AXI4-Stream between NUM_REQ req/ack sources.
// Optional watchdog: define PCIE_TX_ARB_TIMEOUT_EN to release a stalled grant after TIMEOUT_CYCLES.
//
// state   | meaning
// S_IDLE  | no owner; arbitrate among req each cycle
// S_GRANT | source r_gnt owns the stream until tlast, an early req drop, or watchdog expiry
module pcie_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int C_DATA_WIDTH   = 64,
  parameter int KEEP_WIDTH     = C_DATA_WIDTH / 8,
  parameter int TUSER_WIDTH    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              pcie_clk,
  input  logic                              pcie_rst_n,
  input  logic [NUM_REQ-1:0]                req,
  output logic [NUM_REQ-1:0]                ack,
  input  logic [NUM_REQ-1:0]                in_tvalid,
  input  logic [NUM_REQ-1:0]                in_tlast,
  input  logic [NUM_REQ*KEEP_WIDTH-1:0]     in_tkeep,
  input  logic [NUM_REQ*C_DATA_WIDTH-1:0]   in_tdata,
  input  logic [NUM_REQ*TUSER_WIDTH-1:0]    in_tuser,
  output logic [NUM_REQ-1:0]                in_tready,
  input  logic                              pcie_tready,
  output logic                              pcie_tvalid,
  output logic                              pcie_tlast,
  output logic [KEEP_WIDTH-1:0]             pcie_tkeep,
  output logic [C_DATA_WIDTH-1:0]           pcie_tdata,
  output logic [TUSER_WIDTH-1:0]            pcie_tuser,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id,
  output logic                              busy,
  output logic                              err_proto,
  output logic                              err_timeout
);

  localparam int GW = $clog2(NUM_REQ);

  if (C_DATA_WIDTH != 64 || NUM_REQ < 2 || NUM_REQ > 8 ||
      TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("pcie_tx_arbiter: unsupported parameter set");
  end

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t               r_state;
  logic [GW-1:0]        r_gnt;
  logic [GW-1:0]        r_last;
  logic                 r_in_pkt;
  logic [NUM_REQ-1:0]   r_ack;
  logic                 r_err_proto;
  logic                 r_err_timeout;

  logic                 w_found;
  logic [GW-1:0]        w_win;
  int                   w_idx;
  logic                 w_busy;
  logic                 w_beat;
  logic                 w_timeout;

  assign w_busy = (r_state == S_GRANT);
  assign w_beat = w_busy & in_tvalid[r_gnt] & pcie_tready;

  // Scan starts one past the previous winner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(r_last) + k) % NUM_REQ;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = GW'(w_idx);
      end
    end
  end

`ifdef PCIE_TX_ARB_TIMEOUT_EN
  logic [15:0] r_wd;

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      r_wd <= '0;
    end else if (!w_busy || w_beat) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + 16'd1;
    end
  end

  // Fires on the stalled cycle that brings the count to TIMEOUT_CYCLES.
  assign w_timeout = w_busy && !w_beat && (r_wd == 16'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      r_state       <= S_IDLE;
      r_gnt         <= '0;
      r_last        <= GW'(NUM_REQ - 1);
      r_in_pkt      <= 1'b0;
      r_ack         <= '0;
      r_err_proto   <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state  <= S_GRANT;
            r_gnt    <= w_win;
            r_last   <= w_win;
            r_in_pkt <= 1'b0;
            r_ack    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
          end
        end
        S_GRANT: begin
          if (!req[r_gnt] && r_in_pkt) begin
            r_err_proto <= 1'b1;
          end
          if (w_beat) begin
            if (in_tlast[r_gnt]) begin
              r_state  <= S_IDLE;
              r_ack    <= '0;
              r_in_pkt <= 1'b0;
            end else begin
              r_in_pkt <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state       <= S_IDLE;
            r_ack         <= '0;
            r_in_pkt      <= 1'b0;
            r_err_timeout <= 1'b1;
            r_last        <= r_gnt;
          end else if (!req[r_gnt] && !r_in_pkt) begin
            r_state <= S_IDLE;
            r_ack   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Zero-latency data path; gated by state so an async reset silences it immediately.
  always_comb begin
    pcie_tvalid = 1'b0;
    pcie_tlast  = 1'b0;
    pcie_tkeep  = '0;
    pcie_tdata  = '0;
    pcie_tuser  = '0;
    in_tready   = '0;
    if (w_busy) begin
      pcie_tvalid      = in_tvalid[r_gnt];
      pcie_tlast       = in_tlast[r_gnt];
      pcie_tkeep       = in_tkeep[int'(r_gnt)*KEEP_WIDTH +: KEEP_WIDTH];
      pcie_tdata       = in_tdata[int'(r_gnt)*C_DATA_WIDTH +: C_DATA_WIDTH];
      pcie_tuser       = in_tuser[int'(r_gnt)*TUSER_WIDTH +: TUSER_WIDTH];
      in_tready[r_gnt] = pcie_tready;
    end
  end

  assign ack         = r_ack;
  assign busy        = w_busy;
  assign grant_id    = r_gnt;
  assign err_proto   = r_err_proto;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Bench for pcie_tx_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level owner/pointer model of the arbitration rules.
module tb_pcie_tx_arbiter;
  localparam int N   = 3;
  localparam int DW  = 64;
  localparam int KW  = 8;
  localparam int UW  = 4;
  localparam int TMO = 16;
`ifdef PCIE_TX_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req, ack, in_tvalid, in_tlast, in_tready;
  logic [N*KW-1:0]   in_tkeep;
  logic [N*DW-1:0]   in_tdata;
  logic [N*UW-1:0]   in_tuser;
  logic              pcie_tready, pcie_tvalid, pcie_tlast;
  logic [KW-1:0]     pcie_tkeep;
  logic [DW-1:0]     pcie_tdata;
  logic [UW-1:0]     pcie_tuser;
  logic [1:0]        grant_id;
  logic              busy, err_proto, err_timeout;

  pcie_tx_arbiter #(.NUM_REQ(N), .C_DATA_WIDTH(DW), .KEEP_WIDTH(KW),
                    .TUSER_WIDTH(UW), .TIMEOUT_CYCLES(TMO)) dut (
    .pcie_clk(clk), .pcie_rst_n(rst_n), .req(req), .ack(ack),
    .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tkeep(in_tkeep),
    .in_tdata(in_tdata), .in_tuser(in_tuser), .in_tready(in_tready),
    .pcie_tready(pcie_tready), .pcie_tvalid(pcie_tvalid), .pcie_tlast(pcie_tlast),
    .pcie_tkeep(pcie_tkeep), .pcie_tdata(pcie_tdata), .pcie_tuser(pcie_tuser),
    .grant_id(grant_id), .busy(busy), .err_proto(err_proto), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: owner = -1 when nobody holds the stream.
  int       m_owner, m_last, m_gid, m_stall;
  bit       m_inpkt, m_ep, m_et;
  bit [N-1:0] m_acc;
  int       src_len [N];
  int       src_seq [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_gid = 0; m_stall = 0;
    m_inpkt = 0; m_ep = 0; m_et = 0; m_acc = '0;
  endtask

  function automatic int pick();
    for (int k = 1; k <= N; k++)
      if (req[(m_last + k) % N]) return (m_last + k) % N;
    return -1;
  endfunction

  task automatic model_check();
    bit g;
    g = (m_owner >= 0);
    chk("busy",        busy, g);
    chk("ack",         ack, g ? (64'd1 << m_owner) : 64'd0);
    chk("grant_id",    grant_id, m_gid);
    chk("err_proto",   err_proto, m_ep);
    chk("err_timeout", err_timeout, m_et);
    chk("in_tready",   in_tready, (g && pcie_tready) ? (64'd1 << m_owner) : 64'd0);
    chk("pcie_tvalid", pcie_tvalid, g ? in_tvalid[m_owner] : 1'b0);
    chk("pcie_tlast",  pcie_tlast,  g ? in_tlast[m_owner]  : 1'b0);
    chk("pcie_tkeep",  pcie_tkeep,  g ? in_tkeep[m_owner*KW +: KW] : '0);
    chk("pcie_tdata",  pcie_tdata,  g ? in_tdata[m_owner*DW +: DW] : '0);
    chk("pcie_tuser",  pcie_tuser,  g ? in_tuser[m_owner*UW +: UW] : '0);
  endtask

  task automatic model_update();
    int o, w;
    m_acc = '0;
    if (m_owner < 0) begin
      w = pick();
      if (w >= 0) begin
        m_owner = w; m_last = w; m_gid = w; m_inpkt = 0; m_stall = 0;
      end
    end else begin
      o = m_owner;
      if (!req[o] && m_inpkt) m_ep = 1;
      if (in_tvalid[o] && pcie_tready) begin
        m_acc[o] = 1; m_stall = 0;
        if (in_tlast[o]) begin m_owner = -1; m_inpkt = 0; end
        else m_inpkt = 1;
      end else begin
        m_stall++;
        if (TMO_EN && m_stall >= TMO) begin
          m_et = 1; m_owner = -1; m_inpkt = 0;
        end else if (!req[o] && !m_inpkt) begin
          m_owner = -1;
        end
      end
    end
  endtask

  task automatic probe();
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst_n) model_update(); else model_reset();
    for (int i = 0; i < N; i++)
      if (m_acc[i]) begin
        src_seq[i]++;
        if (src_len[i] > 0) src_len[i]--;
      end
    #1;
  endtask

  task automatic step();
    probe();
    adv();
  endtask

  task automatic clear_in();
    req = '0; in_tvalid = '0; in_tlast = '0;
    in_tkeep = '0; in_tdata = '0; in_tuser = '0;
    for (int i = 0; i < N; i++) begin src_len[i] = 0; src_seq[i] = 0; end
  endtask

  task automatic drive(input int i, input bit r, input bit v, input bit l,
                       input logic [63:0] d, input logic [7:0] k);
    req[i] = r; in_tvalid[i] = v; in_tlast[i] = l;
    in_tdata[i*DW +: DW] = d; in_tkeep[i*KW +: KW] = k;
    in_tuser[i*UW +: UW] = UW'(i + 1);
  endtask

  task automatic drive_sources(input bit rnd, input bit allow_new);
    for (int i = 0; i < N; i++) begin
      if (allow_new && src_len[i] == 0 && $urandom_range(0, 2) == 0)
        src_len[i] = $urandom_range(1, 4);
      req[i]       = (src_len[i] != 0);
      in_tvalid[i] = (src_len[i] != 0) && (!rnd || $urandom_range(0, 3) != 0);
      in_tlast[i]  = (src_len[i] == 1);
      in_tdata[i*DW +: DW] = rnd ? {$urandom, $urandom} : {32'hD0 + 32'(i), 32'(src_seq[i])};
      in_tkeep[i*KW +: KW] = rnd ? KW'($urandom) : 8'hFF;
      in_tuser[i*UW +: UW] = rnd ? UW'($urandom) : UW'(i);
    end
    if (rnd) pcie_tready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_in();
    pcie_tready = 1'b1;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  int pend, guard;
  logic [3:0] exp_ack [12];
  logic [1:0] exp_gid [12];

  initial begin
    exp_ack = '{0, 1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2};
    exp_gid = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
    do_reset();

    // Reset values
    probe();
    chk("rst_ack", ack, 0); chk("rst_busy", busy, 0); chk("rst_gid", grant_id, 0);
    chk("rst_errp", err_proto, 0); chk("rst_errt", err_timeout, 0);
    adv();

    // Single requester, 3-beat TLP
    repeat (3) step();
    drive(0, 1, 0, 0, 64'h0, 8'h00);
    probe(); chk("single_ack_pre", ack, 0); adv();
    drive(0, 1, 1, 0, 64'hA0, 8'hFF);
    probe(); chk("single_ack", ack, 1); chk("single_d0", pcie_tdata, 64'hA0);
    chk("single_k0", pcie_tkeep, 8'hFF); adv();
    drive(0, 1, 1, 0, 64'hA1, 8'hFF);
    probe(); chk("single_d1", pcie_tdata, 64'hA1); adv();
    drive(0, 1, 1, 1, 64'hA2, 8'hFF);
    probe(); chk("single_d2", pcie_tdata, 64'hA2); chk("single_last", pcie_tlast, 1);
    chk("single_ack_last", ack, 1); adv();
    drive(0, 0, 0, 0, 64'h0, 8'h00);
    probe(); chk("single_ack_fall", ack, 0); adv();

    // Round-robin fairness: two always-requesting sources with 2-beat packets
    do_reset();
    for (int s = 0; s < 12; s++) begin
      for (int i = 0; i < 2; i++) if (src_len[i] == 0) src_len[i] = 2;
      drive_sources(0, 0);
      probe();
      chk("rr_ack", ack, exp_ack[s]);
      chk("rr_gid", grant_id, exp_gid[s]);
      adv();
    end
    clear_in();
    step();

    // Backpressure: 4 stalled cycles in the middle of source 0's packet
    src_len[0] = 3; src_len[1] = 1;
    drive_sources(0, 0); step();
    drive_sources(0, 0); step();
    pcie_tready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      drive_sources(0, 0);
      probe();
      chk("bp_tready", in_tready, 0);
      chk("bp_hold", pcie_tdata, {32'hD0, 32'd1});
      chk("bp_ack", ack, 1);
      adv();
    end
    pcie_tready = 1'b1;
    guard = 0;
    while ((src_len[0] + src_len[1]) != 0 && guard < 40) begin
      drive_sources(0, 0); step(); guard++;
    end
    chk("bp_drain", (src_len[0] + src_len[1]) == 0, 1);
    chk("bp_seq0", src_seq[0], 3);
    clear_in(); step();

    // Empty grant release
    drive(1, 1, 0, 0, 64'h0, 8'h00); step();
    drive(1, 0, 0, 0, 64'h0, 8'h00);
    probe(); chk("empty_ack", ack, 2); adv();
    probe(); chk("empty_rel", ack, 0); chk("empty_busy", busy, 0); adv();

    // req dropped after beat 1 of 3
    drive(1, 1, 0, 0, 64'h0, 8'h00); step();
    drive(1, 1, 1, 0, 64'hC0, 8'hFF); step();
    drive(1, 0, 1, 0, 64'hC1, 8'hFF); step();
    drive(1, 0, 1, 1, 64'hC2, 8'h0F);
    probe(); chk("proto_err", err_proto, 1); chk("proto_hold", ack, 2); adv();
    drive(1, 0, 0, 0, 64'h0, 8'h00);
    probe(); chk("proto_rel", ack, 0); chk("proto_sticky", err_proto, 1); adv();

    // Reset mid-packet
    drive(0, 1, 1, 0, 64'hE0, 8'hFF); step();
    step();
    drive(0, 1, 1, 0, 64'hE1, 8'hFF);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_tvalid", pcie_tvalid, 0); chk("rstmid_ack", ack, 0);
    chk("rstmid_tready", in_tready, 0); chk("rstmid_busy", busy, 0);
    chk("rstmid_errp", err_proto, 0);
    model_reset();
    clear_in();
    repeat (2) step();
    rst_n = 1'b1;
    drive(0, 1, 0, 0, 64'h0, 8'h00); drive(1, 1, 0, 0, 64'h0, 8'h00); step();
    probe(); chk("rstmid_first", ack, 1); adv();
    clear_in(); repeat (2) step();

`ifdef PCIE_TX_ARB_TIMEOUT_EN
    // Watchdog: source 0 stalls, source 1 waits
    do_reset();
    drive(0, 1, 0, 0, 64'h0, 8'h00); drive(1, 1, 0, 0, 64'h0, 8'h00); step();
    for (int s = 0; s < TMO; s++) begin
      probe(); chk("tmo_hold", ack, 1); adv();
    end
    probe(); chk("tmo_drop", ack, 0); chk("tmo_err", err_timeout, 1); adv();
    probe(); chk("tmo_next", ack, 2); adv();
    clear_in(); repeat (3) step();
`endif

    // Randomized traffic against the model
    clear_in();
    for (int c = 0; c < 1500; c++) begin
      drive_sources(1, 1);
      step();
    end
    guard = 0;
    pend = 1;
    while (pend != 0 && guard < 300) begin
      drive_sources(1, 0);
      step();
      pend = 0;
      for (int i = 0; i < N; i++) pend += src_len[i];
      guard++;
    end
    chk("rand_drain", pend, 0);
    clear_in();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
